// File: rtl/nios_system_pio_in_capture.sv
//------------------------------------------------------------------------------
// nios_system_pio_in_capture
//
// Avalon-MM parallel input port with edge capture and a level interrupt.
// External inputs are synchronised, compared with their value one clock
// earlier, and the selected edges are latched into a sticky capture
// register. The capture bits are cleared by writing 1s to them. A mask
// register selects which capture bits drive irq.
//
// Register map (word address):
//   0 : data         (RO, synchronised in_port)
//   1 : reserved     (reads 0, writes ignored)
//   2 : irq_mask     (RW)
//   3 : edge_capture (RO, write-1-to-clear)
//
// Parameters:
//   DATA_WIDTH  : in_port width, 1..32
//   SYNC_STAGES : synchroniser depth, 2..4
//   EDGE_TYPE   : 0 = rising, 1 = falling, 2 = any edge
//
// Ports:
//   clk        : single clock
//   reset      : asynchronous, active-high reset
//   address    : word address
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : write data, low DATA_WIDTH bits used
//   in_port    : asynchronous external inputs
//   readdata   : registered read data, 1-cycle latency, zero-extended
//   irq        : combinational OR of (edge_capture & irq_mask)
//------------------------------------------------------------------------------
module nios_system_pio_in_capture #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    // r_sync[0] is the first (metastable) stage, r_sync[SYNC_STAGES-1] the last
    logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sync;
    logic [DATA_WIDTH-1:0]                  r_prev;
    logic [DATA_WIDTH-1:0]                  r_irq_mask;
    logic [DATA_WIDTH-1:0]                  r_edge_capture;
    logic [31:0]                            r_readdata;

    logic [DATA_WIDTH-1:0] w_sync_data;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_clear;
    logic                  w_write;
    logic [31:0]           w_readdata_next;

    assign w_sync_data = r_sync[SYNC_STAGES-1];
    assign w_write     = chipselect & ~write_n;

    // Per-bit edge detection between the synchronised value and its
    // one-clock-delayed copy
    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = w_sync_data & ~r_prev;
            1:       w_edge = ~w_sync_data & r_prev;
            default: w_edge = w_sync_data ^ r_prev;
        endcase
    end

    // Bits written as 1 to edge_capture are cleared
    always_comb begin
        w_clear = '0;
        if (w_write && (address == 2'd3))
            w_clear = writedata[DATA_WIDTH-1:0];
    end

    // Read mux; readdata is refreshed every cycle regardless of chipselect
    always_comb begin
        w_readdata_next = '0;
        case (address)
            2'd0:    w_readdata_next = 32'(w_sync_data);
            2'd2:    w_readdata_next = 32'(r_irq_mask);
            2'd3:    w_readdata_next = 32'(r_edge_capture);
            default: w_readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync         <= '0;
            r_prev         <= '0;
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
            r_readdata     <= '0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], in_port};
            r_prev     <= w_sync_data;
            r_readdata <= w_readdata_next;
            if (w_write && (address == 2'd2))
                r_irq_mask <= writedata[DATA_WIDTH-1:0];
            // OR-ing the new edges after the clear lets a coincident set win
            r_edge_capture <= (r_edge_capture & ~w_clear) | w_edge;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_nios_system_pio_in_capture.sv
//------------------------------------------------------------------------------
// tb_nios_system_pio_in_capture
//
// Three instances share the bus and clock:
//   0 : DATA_WIDTH=8,  SYNC_STAGES=2, rising edges
//   1 : DATA_WIDTH=32, SYNC_STAGES=2, any edge
//   2 : DATA_WIDTH=8,  SYNC_STAGES=3, falling edges
// Each instance has a model built from an input sample history: the
// synchronised value after edge n is the input sampled SYNC_STAGES-1 edges
// earlier. Outputs are compared with the model on every falling clock edge,
// and directed steps add hand-computed literal expectations.
//------------------------------------------------------------------------------
module tb_nios_system_pio_in_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] in_bus [3];

    logic [31:0] exp_rd  [3];
    logic [31:0] got_rd  [3];
    logic        exp_irq [3];
    logic        got_irq [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int DW = (g == 1) ? 32 : 8;
        localparam int ET = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
        localparam int SS = (g == 2) ? 3 : 2;
        localparam logic [31:0] DM = (DW == 32) ? 32'hFFFF_FFFF : ((32'd1 << DW) - 32'd1);

        logic [31:0] rd_w;
        logic        irq_w;

        nios_system_pio_in_capture #(
            .DATA_WIDTH (DW),
            .SYNC_STAGES(SS),
            .EDGE_TYPE  (ET)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .address   (address),
            .chipselect(chipselect),
            .write_n   (write_n),
            .writedata (writedata),
            .in_port   (in_bus[g][DW-1:0]),
            .readdata  (rd_w),
            .irq       (irq_w)
        );

        // hist[j] = in_port as sampled j clock edges ago
        logic [SS:0][31:0] hist;
        logic [31:0]       m_cap;
        logic [31:0]       m_mask;
        logic [31:0]       m_rd;

        function automatic logic [31:0] edges(input logic [31:0] s, input logic [31:0] p);
            if (ET == 0)      return s & ~p & DM;
            else if (ET == 1) return ~s & p & DM;
            else              return (s ^ p) & DM;
        endfunction

        function automatic logic [31:0] clr_bits();
            if (chipselect && !write_n && address == 2'd3) return writedata & DM;
            else                                           return 32'd0;
        endfunction

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                hist   <= '0;
                m_cap  <= '0;
                m_mask <= '0;
                m_rd   <= '0;
            end else begin
                hist  <= {hist[SS-1:0], in_bus[g] & DM};
                m_cap <= (m_cap & ~clr_bits()) | edges(hist[SS-1], hist[SS]);
                if (chipselect && !write_n && address == 2'd2)
                    m_mask <= writedata & DM;
                case (address)
                    2'd0:    m_rd <= hist[SS-1];
                    2'd2:    m_rd <= m_mask;
                    2'd3:    m_rd <= m_cap;
                    default: m_rd <= '0;
                endcase
            end
        end

        assign exp_rd[g]  = m_rd;
        assign exp_irq[g] = |(m_cap & m_mask);
        assign got_rd[g]  = rd_w;
        assign got_irq[g] = irq_w;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_rd[%0d]", i), got_rd[i], exp_rd[i]);
            chk($sformatf("model_irq[%0d]", i), 32'(got_irq[i]), 32'(exp_irq[i]));
        end
    endtask

    // Wait for the next falling edge and compare every output with the model
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cyc();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        for (int i = 0; i < 3; i++) in_bus[i] = '0;

        cyc(3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_rd[%0d]", i), got_rd[i], 32'h0);
            chk($sformatf("reset_irq[%0d]", i), 32'(got_irq[i]), 32'h0);
        end
        reset = 1'b0;
        cyc(2);

        // Rising edge on bit0 with mask 0x01, then clear by write-1
        wr(2'd2, 32'h01);
        address   = 2'd3;
        in_bus[0] = 32'h01;
        cyc(2);
        chk("irq_before_k2", 32'(got_irq[0]), 32'h0);
        cyc();
        chk("irq_after_k2", 32'(got_irq[0]), 32'h1);
        cyc();
        chk("cap_bit0", got_rd[0], 32'h01);
        wr(2'd3, 32'h01);
        chk("irq_cleared", 32'(got_irq[0]), 32'h0);

        // Clear of bit0 coincident with a new bit0 edge: set wins
        in_bus[0] = 32'h00;
        cyc(3);
        in_bus[0] = 32'h01;
        cyc(3);
        chk("cap_again_irq", 32'(got_irq[0]), 32'h1);
        in_bus[0] = 32'h00;
        cyc(3);
        in_bus[0] = 32'h01;
        cyc(2);
        wr(2'd3, 32'h01);
        chk("set_wins_irq", 32'(got_irq[0]), 32'h1);
        cyc();
        chk("set_wins_cap", got_rd[0], 32'h01);
        wr(2'd3, 32'hFF);

        // Masked capture on bit3, then unmask
        wr(2'd2, 32'h00);
        address   = 2'd3;
        in_bus[0] = 32'h09;
        cyc(4);
        chk("masked_cap", got_rd[0], 32'h08);
        chk("masked_irq", 32'(got_irq[0]), 32'h0);
        wr(2'd2, 32'h08);
        chk("unmask_irq", 32'(got_irq[0]), 32'h1);

        // Data path latency: 0x09 -> 0xA5
        address = 2'd0;
        cyc();
        in_bus[0] = 32'hA5;
        cyc(2);
        chk("data_k1", got_rd[0], 32'h09);
        cyc();
        chk("data_k2", got_rd[0], 32'hA5);
        address = 2'd2;
        cyc();
        chk("mask_read", got_rd[0], 32'h08);
        address = 2'd1;
        cyc();
        chk("reserved_read", got_rd[0], 32'h0);

        // Any-edge 32-bit instance and falling-edge instance
        wr(2'd3, 32'hFFFF_FFFF);
        in_bus[1] = 32'hFFFF_FFFF;
        in_bus[2] = 32'hFF;
        cyc(5);
        address = 2'd3;
        cyc();
        chk("fall_ignores_rise", got_rd[2], 32'h0);
        wr(2'd3, 32'hFFFF_FFFF);
        in_bus[1] = 32'h0;
        in_bus[2] = 32'h0;
        cyc(5);
        chk("any_edge_fall", got_rd[1], 32'hFFFF_FFFF);
        chk("fall_capture", got_rd[2], 32'hFF);

        // Reset while captures are pending and irq is high
        wr(2'd3, 32'hFFFF_FFFF);
        in_bus[0] = 32'h00;
        cyc(3);
        wr(2'd3, 32'hFF);
        in_bus[0] = 32'h3C;
        wr(2'd2, 32'h3C);
        address = 2'd3;
        cyc(3);
        chk("pre_reset_cap", got_rd[0], 32'h3C);
        chk("pre_reset_irq", 32'(got_irq[0]), 32'h1);
        in_bus[0] = 32'h01;
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("async_rst_irq[%0d]", i), 32'(got_irq[i]), 32'h0);
            chk($sformatf("async_rst_rd[%0d]", i), got_rd[i], 32'h0);
        end
        cyc(2);
        reset = 1'b0;
        // First edge after release samples 0x01; capture follows two edges later
        cyc(4);
        chk("post_reset_cap", got_rd[0], 32'h01);
        chk("post_reset_irq", 32'(got_irq[0]), 32'h0);
        wr(2'd2, 32'h01);
        chk("post_reset_unmask", 32'(got_irq[0]), 32'h1);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
